if_stage: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC register, next-PC selection (sequential, branch, jump) and the IF/ID pipeline register, including its hold/flush behaviour. It drives the instruction-memory address and feeds the ID stage (decode, register file, hazard and forwarding logic). Hold and flush come from the hazard unit. Branch and jump redirects come from ID.

---
 rtl/if_stage_pkg.sv | 15 +
 rtl/if_stage_if_id_reg.sv | 36 +++
 rtl/if_stage.sv | 84 ++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants for the fetch stage and the ID-side decode that drives its redirects.
// Default reset PC, bubble instruction word, instruction width and the j/jal/beq/bne opcodes.
package if_stage_pkg;

    localparam int unsigned INS_W = 32;

    localparam logic [INS_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INS_W-1:0] NOP_INS_DEFAULT  = 32'h0000_0000;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: holds on stall, otherwise loads either a real fetch or a bubble.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [INS_W-1:0] NOP_INS = NOP_INS_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold,
    input  logic             load,
    input  logic [INS_W-1:0] ins_next,
    input  logic [31:0]      pc4_next,
    output logic [INS_W-1:0] ins,
    output logic [31:0]      pc4,
    output logic             valid
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ins   <= NOP_INS;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                ins   <= ins_next;
                pc4   <= pc4_next;
                valid <= 1'b1;
            end else begin
                ins   <= NOP_INS;
                pc4   <= '0;
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection and the IF/ID register.
// Priority per edge: hold, redirect (branch over jump), flush, memory not ready, normal fetch.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0]      RESET_PC = if_stage_pkg::RESET_PC_DEFAULT,
    parameter logic [INS_W-1:0] NOP_INS  = if_stage_pkg::NOP_INS_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold,
    input  logic             flush,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic             imem_ready,
    input  logic [INS_W-1:0] imem_data,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc,
    output logic [INS_W-1:0] if_id_ins,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic [31:0]      fetch_count
);

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc4;
    logic [31:0] pc_next;
    logic        deliver;

    assign redirect  = branch_taken | jump;
    assign target    = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
    assign pc4       = pc + 32'd4;
    assign imem_addr = pc;

    always_comb begin
        pc_next = pc;
        deliver = 1'b0;
        if (!hold) begin
            if (redirect) begin
                pc_next = target;
            end else if (flush) begin
                pc_next = imem_ready ? pc4 : pc;
            end else if (imem_ready) begin
                pc_next = pc4;
                deliver = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // Counts only real deliveries into IF/ID and sticks at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_count <= '0;
        end else if (deliver && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    if_id_reg #(
        .NOP_INS (NOP_INS)
    ) u_if_id_reg (
        .clock    (clock),
        .reset    (reset),
        .hold     (hold),
        .load     (deliver),
        .ins_next (imem_data),
        .pc4_next (pc4),
        .ins      (if_id_ins),
        .pc4      (if_id_pc4),
        .valid    (if_id_valid)
    );

endmodule
